// File: rtl/motor_duty_ramp_master_if.sv
// Avalon-MM bundle between the duty ramp master and the duty PIO slave.
// Master drives the request side; slave returns data and stall.
interface motor_duty_ramp_master_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] avm_address;
  logic                  avm_write;
  logic [31:0]           avm_writedata;
  logic                  avm_read;
  logic [31:0]           avm_readdata;
  logic                  avm_waitrequest;

  modport master (
    output avm_address,
    output avm_write,
    output avm_writedata,
    output avm_read,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_write,
    input  avm_writedata,
    input  avm_read,
    output avm_readdata,
    output avm_waitrequest
  );
endinterface

// File: rtl/motor_duty_ramp_master.sv
// Avalon-MM master ramping the motor duty PIO one LSB per step.
// Define MOTOR_RAMP_READBACK_VERIFY_EN to read back and check each step.
module motor_duty_ramp_master #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] DUTY_ADDR  = '0,
  parameter int unsigned           DUTY_W     = 3,
  parameter int unsigned           STEP_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DUTY_W-1:0]     target_duty,
  input  logic                  target_valid,
  motor_duty_ramp_master_if.master avm,
  output logic [DUTY_W-1:0]     cur_duty,
  output logic                  busy,
  output logic                  verify_err
);

  localparam logic [23:0] CNT_LOAD = 24'(STEP_DIV - 1);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WAIT_STEP,
    WRITE
`ifdef MOTOR_RAMP_READBACK_VERIFY_EN
    ,
    RD_REQ,
    RD_CHK
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [DUTY_W-1:0] tgt_q;
  logic [DUTY_W-1:0] cur_q, cur_d;
  logic [DUTY_W-1:0] wdata_q, wdata_d;
  logic [23:0]       cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              err_q, err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_q <= '0;
    end else if (target_valid) begin
      tgt_q <= target_duty;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      cur_q   <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    err_d   = err_q;
    unique case (state_q)
      INIT: begin
        wdata_d = '0;
        if (!wr_q) begin
          wr_d = 1'b1;
        end else if (!avm.avm_waitrequest) begin
          wr_d    = 1'b0;
          cur_d   = '0;
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (tgt_q != cur_q) begin
          cnt_d   = CNT_LOAD;
          state_d = WAIT_STEP;
        end
      end
      WAIT_STEP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 24'd1;
        end else if (tgt_q > cur_q) begin
          wdata_d = cur_q + 1'b1;
          wr_d    = 1'b1;
          state_d = WRITE;
        end else if (tgt_q < cur_q) begin
          wdata_d = cur_q - 1'b1;
          wr_d    = 1'b1;
          state_d = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (!avm.avm_waitrequest) begin
          wr_d  = 1'b0;
          cur_d = wdata_q;
`ifdef MOTOR_RAMP_READBACK_VERIFY_EN
          rd_d    = 1'b1;
          state_d = RD_REQ;
`else
          // Fold the idle decision into completion to keep steps STEP_DIV+1 apart
          if (tgt_q != wdata_q) begin
            cnt_d   = CNT_LOAD;
            state_d = WAIT_STEP;
          end else begin
            state_d = IDLE;
          end
`endif
        end
      end
`ifdef MOTOR_RAMP_READBACK_VERIFY_EN
      RD_REQ: begin
        if (!avm.avm_waitrequest) begin
          rd_d    = 1'b0;
          state_d = RD_CHK;
        end
      end
      RD_CHK: begin
        if (avm.avm_readdata[DUTY_W-1:0] != cur_q) begin
          err_d = 1'b1;
        end
        if (tgt_q != cur_q) begin
          cnt_d   = CNT_LOAD;
          state_d = WAIT_STEP;
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = INIT;
    endcase
  end

  assign avm.avm_address   = DUTY_ADDR;
  assign avm.avm_write     = wr_q;
  assign avm.avm_writedata = {{(32-DUTY_W){1'b0}}, wdata_q};
  assign cur_duty          = cur_q;
  assign busy              = (state_q != IDLE) || (tgt_q != cur_q);

`ifdef MOTOR_RAMP_READBACK_VERIFY_EN
  assign avm.avm_read = rd_q;
  assign verify_err   = err_q;

  logic unused_rdata;
  assign unused_rdata = ^avm.avm_readdata[31:DUTY_W];
`else
  assign avm.avm_read = 1'b0;
  assign verify_err   = 1'b0;

  logic unused_rd;
  assign unused_rd = ^{avm.avm_readdata, rd_q, rd_d, err_q, err_d};
`endif

endmodule

// File: tb/tb_motor_duty_ramp_master.sv
// Directed bench for motor_duty_ramp_master with a small Avalon slave model.
// Readback checks run when MOTOR_RAMP_READBACK_VERIFY_EN is defined.
module tb_motor_duty_ramp_master;

  localparam int          STEP  = 4;
  localparam logic [31:0] DADDR = 32'h0000_0040;
`ifdef MOTOR_RAMP_READBACK_VERIFY_EN
  localparam int GAP = STEP + 3;
`else
  localparam int GAP = STEP + 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] target_duty = '0;
  logic       target_valid = 1'b0;
  logic [2:0] cur_duty;
  logic       busy;
  logic       verify_err;

  int n_tests = 0;
  int n_fail  = 0;

  motor_duty_ramp_master_if #(.ADDR_WIDTH(32)) avm ();

  motor_duty_ramp_master #(
    .ADDR_WIDTH(32),
    .DUTY_ADDR (DADDR),
    .DUTY_W    (3),
    .STEP_DIV  (STEP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .target_duty (target_duty),
    .target_valid(target_valid),
    .avm         (avm),
    .cur_duty    (cur_duty),
    .busy        (busy),
    .verify_err  (verify_err)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  logic [2:0] wlog[$];
  int         tlog[$];
  int         n_rw = 0;
  int         n_bad = 0;
  int         n_rd = 0;
  logic [2:0] mem = '0;
  logic       corrupt = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (avm.avm_write && !avm.avm_waitrequest) begin
      wlog.push_back(avm.avm_writedata[2:0]);
      tlog.push_back(cyc);
    end
    if (avm.avm_write && avm.avm_read) n_rw = n_rw + 1;
    if (avm.avm_read) n_rd = n_rd + 1;
    if (avm.avm_write &&
        (avm.avm_address !== DADDR || avm.avm_writedata[31:3] !== 29'd0))
      n_bad = n_bad + 1;
  end

  always @(posedge clk) begin
    if (avm.avm_write && !avm.avm_waitrequest)
      mem <= avm.avm_writedata[2:0];
    if (avm.avm_read && !avm.avm_waitrequest)
      avm.avm_readdata <= (corrupt && mem == 3'd5) ? 32'd6 : {29'd0, mem};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_target(input logic [2:0] t);
    target_duty  = t;
    target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle timeout: busy=%b want 0", nm, busy);
    end
  endtask

  task automatic wait_write(input int budget, input string nm);
    int n;
    n = 0;
    while (avm.avm_write !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    n_tests++;
    if (avm.avm_write !== 1'b1) begin
      n_fail++;
      $display("FAIL %s write timeout: write=%b want 1", nm, avm.avm_write);
    end
  endtask

  task automatic test_reset();
    avm.avm_waitrequest = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (avm.avm_write !== 1'b0 || avm.avm_read !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_req write=%b read=%b want 0 0",
               avm.avm_write, avm.avm_read);
    end
    n_tests++;
    if (cur_duty !== 3'd0 || busy !== 1'b1 || verify_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_state cur=%0d busy=%b err=%b want 0 1 0",
               cur_duty, busy, verify_err);
    end
    n_tests++;
    if (avm.avm_address !== DADDR || avm.avm_writedata !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_bus addr=%h data=%h want %h 0",
               avm.avm_address, avm.avm_writedata, DADDR);
    end
    wlog.delete();
    tlog.delete();
    reset = 1'b0;
    wait_idle(20, "init");
    n_tests++;
    if (wlog.size() != 1 || cur_duty !== 3'd0) begin
      n_fail++;
      $display("FAIL init_write count=%0d cur=%0d want 1 0",
               wlog.size(), cur_duty);
    end else begin
      n_tests++;
      if (wlog[0] !== 3'd0) begin
        n_fail++;
        $display("FAIL init_data got %0d want 0", wlog[0]);
      end
    end
  endtask

  task automatic test_ramp_up();
    logic [2:0] exp_q[$];
    exp_q = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    wlog.delete();
    tlog.delete();
    set_target(3'd5);
    wait_idle(200, "ramp_up");
    n_tests++;
    if (wlog.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL up_count got %0d want %0d", wlog.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++;
        if (wlog[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL up_data[%0d] got %0d want %0d", i, wlog[i], exp_q[i]);
        end
        if (i > 0) begin
          n_tests++;
          if (tlog[i] - tlog[i-1] != GAP) begin
            n_fail++;
            $display("FAIL up_gap[%0d] got %0d want %0d",
                     i, tlog[i] - tlog[i-1], GAP);
          end
        end
      end
    end
    n_tests++;
    if (cur_duty !== 3'd5) begin
      n_fail++;
      $display("FAIL up_cur got %0d want 5", cur_duty);
    end
  endtask

  task automatic test_ramp_down();
    logic [2:0] exp_q[$];
    exp_q = '{3'd4, 3'd3, 3'd2};
    wlog.delete();
    tlog.delete();
    set_target(3'd2);
    wait_idle(200, "ramp_down");
    n_tests++;
    if (wlog.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL dn_count got %0d want %0d", wlog.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++;
        if (wlog[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL dn_data[%0d] got %0d want %0d", i, wlog[i], exp_q[i]);
        end
      end
    end
    n_tests++;
    if (cur_duty !== 3'd2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL dn_end cur=%0d busy=%b want 2 0", cur_duty, busy);
    end
  endtask

  task automatic test_stall();
    wlog.delete();
    tlog.delete();
    avm.avm_waitrequest = 1'b1;
    set_target(3'd3);
    wait_write(50, "stall");
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (avm.avm_write !== 1'b1 || avm.avm_writedata !== 32'd3 ||
          avm.avm_address !== DADDR || cur_duty !== 3'd2) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] wr=%b data=%0d addr=%h cur=%0d want 1 3 %h 2",
                 k, avm.avm_write, avm.avm_writedata, avm.avm_address,
                 cur_duty, DADDR);
      end
      tick();
    end
    avm.avm_waitrequest = 1'b0;
    n_tests++;
    if (avm.avm_write !== 1'b1 || avm.avm_writedata !== 32'd3 ||
        cur_duty !== 3'd2) begin
      n_fail++;
      $display("FAIL stall_last wr=%b data=%0d cur=%0d want 1 3 2",
               avm.avm_write, avm.avm_writedata, cur_duty);
    end
    tick();
    n_tests++;
    if (avm.avm_write !== 1'b0 || cur_duty !== 3'd3) begin
      n_fail++;
      $display("FAIL stall_accept wr=%b cur=%0d want 0 3",
               avm.avm_write, cur_duty);
    end
    wait_idle(100, "stall");
    n_tests++;
    if (wlog.size() != 1) begin
      n_fail++;
      $display("FAIL stall_count got %0d want 1", wlog.size());
    end
  endtask

  task automatic test_retarget();
    logic [2:0] exp_q[$];
    exp_q = '{3'd4, 3'd3, 3'd2, 3'd1};
    wlog.delete();
    tlog.delete();
    avm.avm_waitrequest = 1'b1;
    set_target(3'd7);
    wait_write(50, "retarget");
    set_target(3'd1);
    n_tests++;
    if (avm.avm_write !== 1'b1 || avm.avm_writedata !== 32'd4) begin
      n_fail++;
      $display("FAIL rt_inflight wr=%b data=%0d want 1 4",
               avm.avm_write, avm.avm_writedata);
    end
    tick();
    avm.avm_waitrequest = 1'b0;
    tick();
    n_tests++;
    if (cur_duty !== 3'd4) begin
      n_fail++;
      $display("FAIL rt_commit got %0d want 4", cur_duty);
    end
    wait_idle(300, "retarget");
    n_tests++;
    if (wlog.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rt_count got %0d want %0d", wlog.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++;
        if (wlog[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rt_data[%0d] got %0d want %0d", i, wlog[i], exp_q[i]);
        end
      end
    end
    n_tests++;
    if (cur_duty !== 3'd1) begin
      n_fail++;
      $display("FAIL rt_cur got %0d want 1", cur_duty);
    end
  endtask

  task automatic test_bus_rules();
    n_tests++;
    if (n_rw != 0 || n_bad != 0) begin
      n_fail++;
      $display("FAIL bus_rules rw_overlap=%0d bad_addr_data=%0d want 0 0",
               n_rw, n_bad);
    end
    n_tests++;
    if (verify_err !== 1'b0) begin
      n_fail++;
      $display("FAIL no_err got %b want 0", verify_err);
    end
`ifndef MOTOR_RAMP_READBACK_VERIFY_EN
    n_tests++;
    if (n_rd != 0) begin
      n_fail++;
      $display("FAIL no_read cycles=%0d want 0", n_rd);
    end
`endif
  endtask

`ifdef MOTOR_RAMP_READBACK_VERIFY_EN
  task automatic test_verify();
    corrupt = 1'b1;
    set_target(3'd5);
    wait_idle(300, "verify");
    n_tests++;
    if (verify_err !== 1'b1 || cur_duty !== 3'd5) begin
      n_fail++;
      $display("FAIL verify_set err=%b cur=%0d want 1 5", verify_err, cur_duty);
    end
    set_target(3'd4);
    wait_idle(300, "verify_sticky");
    n_tests++;
    if (verify_err !== 1'b1 || cur_duty !== 3'd4) begin
      n_fail++;
      $display("FAIL verify_sticky err=%b cur=%0d want 1 4",
               verify_err, cur_duty);
    end
    corrupt = 1'b0;
    reset = 1'b1;
    tick();
    n_tests++;
    if (verify_err !== 1'b0 || cur_duty !== 3'd0) begin
      n_fail++;
      $display("FAIL verify_clear err=%b cur=%0d want 0 0",
               verify_err, cur_duty);
    end
    reset = 1'b0;
    wait_idle(20, "verify_reinit");
  endtask
`endif

  initial begin
    avm.avm_waitrequest = 1'b0;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_stall();
    test_retarget();
    test_bus_rules();
`ifdef MOTOR_RAMP_READBACK_VERIFY_EN
    test_verify();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/motor_duty_ramp_master.md
Name: motor_duty_ramp_master

Overview:
- Avalon-MM master that drives the motor duty PIO slave (3-bit duty register at word offset 0) from the initiator side.
- Accepts a target duty from control logic and ramps the slave's duty register one LSB per step toward that target, issuing one Avalon write per step.
- Gives soft-start/soft-stop for motor B without CPU involvement.
- Sits in the Qsys system as a master on the same interconnect as the CPU data master.

Parameters:
- ADDR_WIDTH, 32, width of avm_address.
- DUTY_ADDR, 32'h0000_0000, byte address of the duty PIO data register (offset 0).
- DUTY_W, 3, duty width; matches the slave's out_port width.
- STEP_DIV, 50000, clock cycles between ramp steps; legal range 1..2^24-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- target_duty  in  DUTY_W  requested duty
- target_valid  in  1  one-cycle strobe; latches target_duty
- avm_address  out  ADDR_WIDTH  Avalon address
- avm_write  out  1  Avalon write request
- avm_writedata  out  32  Avalon write data
- avm_read  out  1  Avalon read request (0 unless READBACK_VERIFY_EN)
- avm_readdata  in  32  Avalon read data
- avm_waitrequest  in  1  Avalon stall
- cur_duty  out  DUTY_W  duty last committed to the slave
- busy  out  1  high while cur_duty != target or a transfer is outstanding
- verify_err  out  1  sticky readback mismatch flag (0 unless READBACK_VERIFY_EN)

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: avm_write=0, avm_read=0, avm_address=DUTY_ADDR, avm_writedata=0, cur_duty=0, target register=0, step counter=0, verify_err=0, busy=1, state=INIT.
- Reset asserted mid-transfer drops avm_write/avm_read on the next edge. The interconnect tolerates this.
- FSM states: INIT, IDLE, WAIT_STEP, WRITE, RD_REQ, RD_CHK.
- INIT: issue one write of 0 so the slave matches cur_duty, then go to IDLE.
- IDLE: if target != cur_duty, load step counter with STEP_DIV-1 and go to WAIT_STEP. Otherwise busy=0.
- WAIT_STEP: count down to 0, then:
  - next = cur_duty+1 if target > cur_duty, cur_duty-1 if target < cur_duty;
  - if target == cur_duty at that point (target changed back), return to IDLE with no write.
- WRITE: avm_write=1, avm_address=DUTY_ADDR, avm_writedata={zero pad, next}. All stay stable while avm_waitrequest=1.
- The transfer completes on the first edge with avm_write=1 and avm_waitrequest=0. On that edge:
  - avm_write drops;
  - cur_duty <= next;
  - go to RD_REQ if the feature is compiled in, else IDLE.
- Step arithmetic: unsigned DUTY_W; never wraps. Steps stop at target, and target is always within 0..2^DUTY_W-1.
- target_valid is accepted in any state except INIT, which latches it too. The new target takes effect at the next step decision; an in-flight write is never altered.
- target_valid and write completion in the same cycle: cur_duty takes the written value, and the new target is used from the next decision.
- Step spacing: consecutive write issues are at least STEP_DIV cycles apart (counter start to write start). With zero waitrequest, a full 0→7 ramp takes 7 writes, each STEP_DIV+1 cycles apart.
- busy = (state != IDLE) or (target != cur_duty).
- avm_read and avm_write are never asserted together.

Optional Feature:
- Macro: MOTOR_RAMP_READBACK_VERIFY_EN.
- Defined:
  - After each write completes, RD_REQ asserts avm_read at DUTY_ADDR until avm_waitrequest=0. This is a fixed read latency of 1: readdata is sampled in RD_CHK, the cycle after acceptance.
  - If readdata[DUTY_W-1:0] != cur_duty, verify_err sets (sticky until reset).
  - Then go to IDLE.
  - Each step costs 2 extra cycles plus read stalls.
- Undefined: no RD_REQ/RD_CHK states; avm_read tied 0, verify_err tied 0.

Test Plan:
- Reset release with waitrequest=0 → exactly one write, data 0, address DUTY_ADDR, in INIT; then busy=0, cur_duty=0.
- STEP_DIV=4, target 0→5 → five writes with data 1,2,3,4,5, each spaced 5 cycles apart; cur_duty=5; busy falls after the last write.
- At cur_duty=5, target=2 → writes 4,3,2; no wrap; busy=0 at end.
- waitrequest held high for 3 cycles during the write of 3 → address/data/write stable for those 4 cycles; cur_duty updates only on the accepting edge.
- Target changed 7→1 while a write of 4 is stalled → write 4 completes unchanged, then writes 3,2,1.
- With MOTOR_RAMP_READBACK_VERIFY_EN, model returns readdata=6 after a write of 5 → verify_err=1 and stays 1; reset clears it.
